// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect parameters, arbiter state encoding and helpers.
package axil_pkg;

   localparam int NUMBER_MASTER  = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int MASTER_IDX_W   = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

   typedef enum logic [1:0] {WR_IDLE, WR_GRANT, WR_RESP} axil_arb_wr_state_t;

   function automatic logic [MASTER_IDX_W-1:0] onehot_to_idx(input logic [NUMBER_MASTER-1:0] oh);
      onehot_to_idx = '0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         if (oh[i]) onehot_to_idx = MASTER_IDX_W'(i);
      end
   endfunction

endpackage

// File: rtl/axil_arb_picker.sv
// Combinational request-to-one-hot selector; the search begins at start_i and wraps.
// Tie start_i to zero for plain lowest-index-wins priority.
module axil_arb_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N-1:0]     grant_o
);

   int   idx;
   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(start_i) + off) % N;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: holds a one-hot grant for one AW/W/B transaction.
// Build option AXIL_ARB_WR_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WR_IDLE  | no grant; arbitrate among pending AW/W requests
// WR_GRANT | grant held; waiting for both AW and W handshakes (any order)
// WR_RESP  | AW and W done; waiting for the B handshake to release
module axil_arbiter_wr
   import axil_pkg::*;
(
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [NUMBER_MASTER-1:0] m_axil_awvalid,
   input  logic [NUMBER_MASTER-1:0] m_axil_wvalid,
   input  logic                     s_axil_awvalid,
   input  logic                     s_axil_awready,
   input  logic                     s_axil_wvalid,
   input  logic                     s_axil_wready,
   input  logic                     s_axil_bvalid,
   input  logic                     s_axil_bready,
   output logic [NUMBER_MASTER-1:0] grant_wr,
   output logic                     wr_busy
);

   axil_arb_wr_state_t       state_q, state_d;
   logic [NUMBER_MASTER-1:0] grant_q, grant_d;
   logic                     aw_done_q, aw_done_d;
   logic                     w_done_q, w_done_d;

   logic [NUMBER_MASTER-1:0] req;
   logic [NUMBER_MASTER-1:0] pick_grant;
   logic [MASTER_IDX_W-1:0]  pick_start;
   logic                     aw_hs, w_hs, b_hs;

   assign req   = m_axil_awvalid | m_axil_wvalid;
   assign aw_hs = s_axil_awvalid & s_axil_awready;
   assign w_hs  = s_axil_wvalid & s_axil_wready;
   assign b_hs  = s_axil_bvalid & s_axil_bready;

`ifdef AXIL_ARB_WR_ROUND_ROBIN_EN
   logic [MASTER_IDX_W-1:0] last_grant_q, last_grant_d;

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == WR_IDLE && (|req)) last_grant_d = onehot_to_idx(pick_grant);
   end

   assign pick_start = (last_grant_q == MASTER_IDX_W'(NUMBER_MASTER - 1)) ?
                       '0 : last_grant_q + MASTER_IDX_W'(1);

   always_ff @(posedge aclk) begin
      if (areset) last_grant_q <= '0;
      else        last_grant_q <= last_grant_d;
   end
`else
   assign pick_start = '0;
`endif

   axil_arb_picker #(
      .N     (NUMBER_MASTER),
      .IDX_W (MASTER_IDX_W)
   ) u_picker (
      .req_i   (req),
      .start_i (pick_start),
      .grant_o (pick_grant)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         WR_IDLE: begin
            grant_d = '0;
            if (|req) begin
               grant_d   = pick_grant;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_GRANT;
            end
         end
         WR_GRANT: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (b_hs) begin
               grant_d = '0;
               state_d = WR_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = WR_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= WR_IDLE;
         grant_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign grant_wr = grant_q;
   assign wr_busy  = (state_q != WR_IDLE);

endmodule
